// File: rtl/booth4_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier:
// FSM states, Booth digit codes, default operand width and the digit recoder.
package booth4_pkg;

    localparam int BOOTH_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RESOLVE,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        N1,
        N2
    } booth_digit_e;

    // Maps {b[2i+1], b[2i], b[2i-1]} to a radix-4 Booth digit.
    function automatic booth_digit_e booth_recode(input logic [2:0] bits);
        booth_digit_e digit;
        case (bits)
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = N2;
            3'b101, 3'b110: digit = N1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/compressor_3_2.sv
// Single-bit 3:2 compressor (full adder) used as the cell of csa_row.
module compressor_3_2 (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_row.sv
// One carry-save row of 3:2 compressors. The carry output is left unshifted;
// the parent aligns and truncates it.
module csa_row #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_cell
            compressor_3_2 u_cmp (
                .x (x[gi]),
                .y (y[gi]),
                .z (z[gi]),
                .s (s[gi]),
                .c (c[gi])
            );
        end
    endgenerate

endmodule

// File: rtl/booth4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier: one partial product per cycle
// into a carry-save accumulator, then one carry-propagate add. Optional macro: BOOTH_SEQ_ZERO_SKIP_EN.
module booth4_seq_mult
    import booth4_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH_DEFAULT
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH / 2 - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    sum_q, sum_d;
    logic [PW-1:0]    carry_q, carry_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    product_q, product_d;

    booth_digit_e     digit;
    logic [PW-1:0]    a_ext, mult, pp, inj, csa_z, csa_s, csa_c;
    logic             neg_cur;

    // The +1 of a negative digit is deferred one step: it lands in the empty
    // low bits of the next partial product, and the last one is added in RESOLVE.
    always_comb begin
        a_ext   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        digit   = booth_recode(3'({b_q, 1'b0} >> {cnt_q, 1'b0}));
        mult    = '0;
        neg_cur = 1'b0;
        case (digit)
            P1: mult = a_ext;
            P2: mult = a_ext << 1;
            N1: begin mult = ~a_ext;        neg_cur = 1'b1; end
            N2: begin mult = ~(a_ext << 1); neg_cur = 1'b1; end
            default: mult = '0;
        endcase
        pp    = mult << {cnt_q, 1'b0};
        inj   = (PW'(neg_q) << {cnt_q, 1'b0}) >> 2;
        csa_z = pp | inj;
    end

    csa_row #(.W(PW)) u_csa_row (
        .x (sum_q),
        .y (carry_q),
        .z (csa_z),
        .s (csa_s),
        .c (csa_c)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        neg_d     = neg_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    carry_d = '0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ACC;
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        product_d = '0;
                        state_d   = DONE;
                    end
`endif
                end
            end
            ACC: begin
                sum_d   = csa_s;
                carry_d = csa_c << 1;
                neg_d   = neg_cur;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                product_d = sum_q + carry_q + (PW'(neg_q) << (WIDTH - 2));
                state_d   = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign product     = product_q;

endmodule
